// File: rtl/ldpc_decode.sv
// Hard-decision bit-flip LDPC decoder for a systematic (N,K) code.
// Define LDPC_DECODE_SYNDROME_OUT_EN to add the registered o_syndrome output.
module ldpc_decode #(
   parameter int N        = 6,
   parameter int K        = 3,
   parameter int MAX_ITER = 8,
   parameter int ITER_W   = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_en,
   input  logic [N-1:0]          codeword,
   input  logic [K*(N-K)-1:0]    generator_p,
   output logic [K-1:0]          o_info,
   output logic                  o_valid,
   output logic                  o_success,
   output logic [ITER_W-1:0]     o_iter,
   output logic                  o_busy
`ifdef LDPC_DECODE_SYNDROME_OUT_EN
   ,
   output logic [N-K-1:0]        o_syndrome
`endif
);

   localparam int M  = N - K;
   localparam int CW = $clog2(M + 1);

   typedef enum logic [1:0] {IDLE, SYND, FLIP, DONE} state_t;

   state_t              state_q, state_d;
   logic [N-1:0]        word_q;
   logic [K*M-1:0]      gp_q;
   logic [ITER_W-1:0]   iter_q;
   logic [K-1:0]        info_q;
   logic                valid_q;
   logic                success_q;
   logic [ITER_W-1:0]   oiter_q;
`ifdef LDPC_DECODE_SYNDROME_OUT_EN
   logic [M-1:0]        synd_q;
`endif

   logic [M-1:0]        synd;
   logic [CW-1:0]       cnt [N];
   logic [CW-1:0]       max_cnt;
   logic [N-1:0]        flip_mask;
   logic                capture, flip_en, finish;

   always_comb begin
      synd = '0;
      for (int unsigned i = 0; i < M; i++) begin
         synd[i] = word_q[i];
         for (int unsigned j = 0; j < K; j++)
            synd[i] = synd[i] ^ (word_q[M+j] & gp_q[j*M+i]);
      end
   end

   // Per-bit unsatisfied-check counts; every bit tied at the maximum is flipped.
   always_comb begin
      max_cnt   = '0;
      flip_mask = '0;
      for (int unsigned b = 0; b < N; b++) cnt[b] = '0;
      for (int unsigned i = 0; i < M; i++) cnt[i] = CW'(synd[i]);
      for (int unsigned j = 0; j < K; j++)
         for (int unsigned i = 0; i < M; i++)
            cnt[M+j] = cnt[M+j] + CW'(synd[i] & gp_q[j*M+i]);
      for (int unsigned b = 0; b < N; b++)
         if (cnt[b] > max_cnt) max_cnt = cnt[b];
      for (int unsigned b = 0; b < N; b++)
         flip_mask[b] = (cnt[b] == max_cnt);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (i_en) state_d = SYND;
         SYND: begin
            if ((synd == '0) || (iter_q == ITER_W'(MAX_ITER))) state_d = DONE;
            else                                                state_d = FLIP;
         end
         FLIP: state_d = SYND;
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      o_busy  = (state_q != IDLE);
      capture = (state_q == IDLE) && i_en;
      flip_en = (state_q == FLIP);
      finish  = (state_q == SYND) && (state_d == DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         word_q    <= '0;
         gp_q      <= '0;
         iter_q    <= '0;
         info_q    <= '0;
         valid_q   <= 1'b0;
         success_q <= 1'b0;
         oiter_q   <= '0;
`ifdef LDPC_DECODE_SYNDROME_OUT_EN
         synd_q    <= '0;
`endif
      end else begin
         valid_q <= finish;
         if (capture) begin
            word_q <= codeword;
            gp_q   <= generator_p;
            iter_q <= '0;
         end
         if (flip_en) begin
            word_q <= word_q ^ flip_mask;
            iter_q <= iter_q + ITER_W'(1);
         end
         if (finish) begin
            info_q    <= word_q[N-1:M];
            success_q <= (synd == '0);
            oiter_q   <= iter_q;
`ifdef LDPC_DECODE_SYNDROME_OUT_EN
            synd_q    <= synd;
`endif
         end
      end
   end

   assign o_info    = info_q;
   assign o_valid   = valid_q;
   assign o_success = success_q;
   assign o_iter    = oiter_q;
`ifdef LDPC_DECODE_SYNDROME_OUT_EN
   assign o_syndrome = synd_q;
`endif

endmodule

// File: tb/tb_ldpc_decode.sv
// Scoreboard bench for ldpc_decode: two instances (MAX_ITER=8 and MAX_ITER=0) checked
// against a behavioural bit-flip model; honours LDPC_DECODE_SYNDROME_OUT_EN.
module tb_ldpc_decode;

   localparam logic [8:0] GP = 9'b110_101_011;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       i_en = 1'b0;
   logic [5:0] codeword = '0;
   logic [8:0] generator_p = GP;

   logic [2:0] info_a, info_b;
   logic       valid_a, valid_b, succ_a, succ_b, busy_a, busy_b;
   logic [3:0] iter_a, iter_b;
   logic [2:0] syn_a, syn_b;

   always #5 clk = ~clk;

   ldpc_decode #(.N(6), .K(3), .MAX_ITER(8), .ITER_W(4)) dut_a (
      .clk(clk), .rst(rst), .i_en(i_en), .codeword(codeword), .generator_p(generator_p),
      .o_info(info_a), .o_valid(valid_a), .o_success(succ_a), .o_iter(iter_a), .o_busy(busy_a)
`ifdef LDPC_DECODE_SYNDROME_OUT_EN
      , .o_syndrome(syn_a)
`endif
   );

   ldpc_decode #(.N(6), .K(3), .MAX_ITER(0), .ITER_W(4)) dut_b (
      .clk(clk), .rst(rst), .i_en(i_en), .codeword(codeword), .generator_p(generator_p),
      .o_info(info_b), .o_valid(valid_b), .o_success(succ_b), .o_iter(iter_b), .o_busy(busy_b)
`ifdef LDPC_DECODE_SYNDROME_OUT_EN
      , .o_syndrome(syn_b)
`endif
   );

`ifndef LDPC_DECODE_SYNDROME_OUT_EN
   assign syn_a = '0;
   assign syn_b = '0;
`endif

   typedef struct {
      logic [2:0] info;
      logic       succ;
      logic [3:0] iter;
      logic [2:0] syn;
      int         due;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // Decode by the rules directly: syndrome from parity sums mod 2, flip all max-count bits.
   function automatic exp_t model(input logic [5:0] cw, input logic [8:0] gp, input int maxit);
      exp_t e;
      int   v[6];
      int   s[3];
      int   cnt[6];
      int   it, nz, mx;
      bit   done;
      for (int b = 0; b < 6; b++) v[b] = int'(cw[b]);
      it = 0; done = 1'b0; nz = 0;
      while (!done) begin
         nz = 0;
         for (int i = 0; i < 3; i++) begin
            s[i] = v[i];
            for (int j = 0; j < 3; j++) s[i] += v[3+j] * int'(gp[j*3+i]);
            s[i] = s[i] % 2;
            nz += s[i];
         end
         if (nz == 0 || it == maxit) begin
            done = 1'b1;
         end else begin
            mx = 0;
            for (int i = 0; i < 3; i++) cnt[i] = s[i];
            for (int j = 0; j < 3; j++) begin
               cnt[3+j] = 0;
               for (int i = 0; i < 3; i++) cnt[3+j] += s[i] * int'(gp[j*3+i]);
            end
            for (int b = 0; b < 6; b++) if (cnt[b] > mx) mx = cnt[b];
            for (int b = 0; b < 6; b++) if (cnt[b] == mx) v[b] = 1 - v[b];
            it++;
         end
      end
      for (int k = 0; k < 3; k++) begin
         e.info[k] = (v[3+k] != 0);
         e.syn[k]  = (s[k] != 0);
      end
      e.succ = (nz == 0);
      e.iter = 4'(it);
      e.due  = 0;
      return e;
   endfunction

   task automatic check_out(input int d, input logic v, input logic [2:0] info,
                            input logic succ, input logic [3:0] iter, input logic [2:0] syn);
      exp_t e;
      string t;
      t = (d == 0) ? "A" : "B";
      if (v) begin
         if ((d == 0 && qa.size() == 0) || (d == 1 && qb.size() == 0)) begin
            n_cmp++; n_bad++;
            $display("FAIL %s unexpected o_valid: got 1, expected 0 (t=%0t)", t, $time);
         end else begin
            e = (d == 0) ? qa.pop_front() : qb.pop_front();
            cmp({t, " o_info"}, 32'(info), 32'(e.info));
            cmp({t, " o_success"}, 32'(succ), 32'(e.succ));
            cmp({t, " o_iter"}, 32'(iter), 32'(e.iter));
            cmp({t, " latency_cycle"}, 32'(cyc), 32'(e.due));
`ifdef LDPC_DECODE_SYNDROME_OUT_EN
            cmp({t, " o_syndrome"}, 32'(syn), 32'(e.syn));
`else
            if (syn !== 3'b000) begin end
`endif
         end
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         check_out(0, valid_a, info_a, succ_a, iter_a, syn_a);
         check_out(1, valid_b, info_b, succ_b, iter_b, syn_b);
      end
   end

   task automatic check_zero(input string t, input logic [2:0] info, input logic v,
                             input logic succ, input logic [3:0] iter, input logic busy,
                             input logic [2:0] syn);
      cmp({t, " rst o_info"}, 32'(info), 0);
      cmp({t, " rst o_valid"}, 32'(v), 0);
      cmp({t, " rst o_success"}, 32'(succ), 0);
      cmp({t, " rst o_iter"}, 32'(iter), 0);
      cmp({t, " rst o_busy"}, 32'(busy), 0);
`ifdef LDPC_DECODE_SYNDROME_OUT_EN
      cmp({t, " rst o_syndrome"}, 32'(syn), 0);
`else
      if (syn !== 3'b000) begin end
`endif
   endtask

   // Called at negedge+1; returns at negedge+1 with both instances idle.
   task automatic wait_idle();
      int n;
      n = 0;
      while ((busy_a || busy_b) && n < 40) begin
         @(negedge clk); #1;
         n++;
      end
      if (busy_a || busy_b) begin
         n_cmp++; n_bad++;
         $display("FAIL idle_timeout: busy still 1, expected 0 (t=%0t)", $time);
      end
   endtask

   task automatic issue(input logic [5:0] cw, input logic [8:0] gp);
      exp_t ea, eb;
      wait_idle();
      codeword    = cw;
      generator_p = gp;
      i_en        = 1'b1;
      ea = model(cw, gp, 8); ea.due = cyc + 2 + 2 * int'(ea.iter); qa.push_back(ea);
      eb = model(cw, gp, 0); eb.due = cyc + 2;                      qb.push_back(eb);
      @(negedge clk); #1;
      i_en = 1'b0;
   endtask

   initial begin
      int n;
      repeat (2) @(negedge clk);
      #1;
      check_zero("A", info_a, valid_a, succ_a, iter_a, busy_a, syn_a);
      check_zero("B", info_b, valid_b, succ_b, iter_b, busy_b, syn_b);
      rst = 1'b0;

      issue(6'b101101, GP);
      issue(6'b001101, GP);

      // second request while both decoders are busy must be dropped
      issue(6'b001101, GP);
      codeword = 6'b000000; i_en = 1'b1;
      repeat (2) begin @(negedge clk); #1; end
      i_en = 1'b0;

      // reset during FLIP of the single-error decode
      issue(6'b001101, GP);
      @(negedge clk); #1;
      rst = 1'b1;
      #1;
      check_zero("A", info_a, valid_a, succ_a, iter_a, busy_a, syn_a);
      check_zero("B", info_b, valid_b, succ_b, iter_b, busy_b, syn_b);
      qa.delete();
      qb.delete();
      @(negedge clk); #1;
      rst = 1'b0;
      issue(6'b101101, GP);

      for (int k = 0; k < 30; k++) issue(6'($urandom), GP);
      for (int k = 0; k < 30; k++) begin
         issue(6'($urandom), 9'($urandom));
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
         #0;
      end

      n = 0;
      while ((qa.size() != 0 || qb.size() != 0) && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (qa.size() != 0 || qb.size() != 0) begin
         n_cmp++; n_bad++;
         $display("FAIL drain_timeout: %0d results outstanding, expected 0", qa.size() + qb.size());
      end
      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
      $finish;
   end

endmodule
